// File: rtl/out_pattern_gen_if.sv
// out_pattern_gen_if: control and pattern bus between the pattern generator and its user.
interface out_pattern_gen_if #(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 2,
  parameter int PRESCALE_W = 16
);
  logic                      en;
  logic [PRESCALE_W-1:0]     div;
  logic [2*CHANNELS-1:0]     mode;
  logic                      load;
  logic [CHANNELS-1:0]       load_mask;
  logic [WIDTH-1:0]          load_val;
  logic [WIDTH*CHANNELS-1:0] out;
  logic                      tick;
  logic [CHANNELS-1:0]       wrap;
  modport master (output en, div, mode, load, load_mask, load_val, input out, tick, wrap);
  modport slave  (input en, div, mode, load, load_mask, load_val, output out, tick, wrap);
endinterface

// File: rtl/out_pattern_gen.sv
// out_pattern_gen: multi-lane up/down/LFSR/walking-one generator on a shared prescaler tick.
module out_pattern_gen #(
  parameter int                 WIDTH      = 8,
  parameter int                 CHANNELS   = 2,
  parameter int                 PRESCALE_W = 16,
  parameter logic [WIDTH-1:0]   LFSR_TAPS  = 8'hB8
) (
  input logic               ref_clk,
  input logic               rst_n,
  out_pattern_gen_if.slave  bus
);
  localparam logic [WIDTH-1:0] ONE = 1;
  logic [PRESCALE_W-1:0]     cnt;
  logic                      step;
  logic                      tick_q;
  logic [WIDTH*CHANNELS-1:0] out_q, nxt;
  logic [CHANNELS-1:0]       wrap_q, nwr;
  // cnt >= div (not ==) so lowering div below cnt steps on the next enabled edge
  assign step = bus.en && cnt >= bus.div;
  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    logic [WIDTH-1:0] v, lfsr, sv;
    logic [1:0]       m;
    logic             sw, ld;
    assign v    = out_q[k*WIDTH +: WIDTH];
    assign m    = bus.mode[2*k +: 2];
    assign ld   = bus.load && bus.load_mask[k];
    assign lfsr = (v >> 1) ^ (v[0] ? LFSR_TAPS : '0);
    assign sv   = m == 2'd0 ? v + 1'b1 :
                  m == 2'd1 ? v - 1'b1 :
                  v == '0   ? ONE :
                  m == 2'd2 ? lfsr : {v[WIDTH-2:0], v[WIDTH-1]};
    assign sw   = m == 2'd0 ? &v :
                  m == 2'd1 ? ~|v :
                  v == '0   ? 1'b0 :
                  m == 2'd2 ? lfsr == ONE : v[WIDTH-1];
    assign nxt[k*WIDTH +: WIDTH] = ld ? bus.load_val : step ? sv : v;
    assign nwr[k] = !ld && step && sw;
  end
  always_ff @(posedge ref_clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      tick_q <= 1'b0;
      out_q  <= '0;
      wrap_q <= '0;
    end else begin
      cnt    <= step ? '0 : bus.en ? cnt + 1'b1 : cnt;
      tick_q <= step;
      out_q  <= nxt;
      wrap_q <= nwr;
    end
  end
  assign bus.out  = out_q;
  assign bus.tick = tick_q;
  assign bus.wrap = wrap_q;
endmodule
